fft_output_reader: RTL and testbench
====================================

FFT_OUTPUT_READER -- requirements
Module: fft_output_reader

Interface
REQ-001 Parameter DATA_W, default 16, width of each real and imaginary part.
REQ-002 Parameter RD_LAT, default 2, bank RAM read latency in cycles, from address/enable to data.
REQ-003 iCLK  in  1  single clock; all logic on rising edge.
REQ-004 iRESET  in  1  reset, synchronous, active-high.
REQ-005 iFFT_RDY  in  1  transform-complete level from the FFT controller; a frame starts on its 0->1 edge.
REQ-006 oRD_EN  out  1  bank read enable.
REQ-007 oRD_BANK  out  2  bank select for the current read.
REQ-008 oRD_ADDR  out  9  word address within the bank.
REQ-009 iRD_DATA_0..iRD_DATA_3  in  2*DATA_W each  bank read data {re,im}, valid RD_LAT cycles after oRD_EN.
REQ-010 oVALID  out  1  output sample valid.
REQ-011 iREADY  in  1  downstream ready.
REQ-012 oDATA  out  2*DATA_W  output sample {re,im}.
REQ-013 oINDEX  out  11  natural-order frequency index of oDATA.
REQ-014 oLAST  out  1  high with index 2047.
REQ-015 oBUSY  out  1  high from accepted start until the last handshake.
REQ-016 oDONE  out  1  one-cycle pulse the cycle after the index-2047 handshake.

Function
REQ-017 The block streams all 2048 results in natural order 0..2047, one per oVALID&iREADY handshake.
REQ-018 Index n is split as n = {d5[0], d4[1:0], d3[1:0], d2[1:0], d1[1:0], d0[1:0]}; storage position p = {d0,d1,d2,d3,d4,d5}; bank = p[10:9], address = p[8:0].
REQ-019 State machine IDLE -> RUN on the iFFT_RDY rising edge; RUN -> DRAIN after the read for index 2047 issues; DRAIN -> IDLE on the index-2047 handshake.
REQ-020 In IDLE, iFFT_RDY edges are detected against a registered copy; while oBUSY, edges are ignored.
REQ-021 Reads issue in index order; oRD_EN asserts only while (reads in flight + FIFO occupancy) < FIFO depth (4).
REQ-022 Each read's bank is delayed RD_LAT cycles alongside its enable and used to mux the matching iRD_DATA_x into the FIFO.
REQ-023 oDATA/oINDEX/oLAST come from the FIFO head; oVALID = FIFO not empty; pop on oVALID&iREADY.
REQ-024 oDATA, oINDEX and oLAST hold stable while oVALID=1 and iREADY=0.
REQ-025 With iREADY held high, first oVALID occurs RD_LAT+1 cycles after the start edge, then one sample per cycle with no bubbles.
REQ-026 Simultaneous FIFO push and pop in one cycle leaves occupancy unchanged; neither is dropped.
REQ-027 The read index counter is 11 bits and does not wrap within a frame; it clears to 0 on entry to RUN.
REQ-028 No arithmetic on sample data; oDATA equals stored data bit-exactly.

Reset
REQ-029 On iRESET=1 at a clock edge: state=IDLE, FIFO emptied, in-flight pipeline cleared, edge register=1 (a level already high does not start a frame).
REQ-030 Output reset values: oRD_EN=0, oRD_BANK=0, oRD_ADDR=0, oVALID=0, oDATA=0, oINDEX=0, oLAST=0, oBUSY=0, oDONE=0.
REQ-031 Reset mid-frame aborts the frame; no further reads or samples until a new iFFT_RDY rising edge.

Structure
REQ-032 Shared package fft_pkg holds N_FFT=2048, BANK_ADDR_W=9, INDEX_W=11, and the digit-reverse index-to-(bank,addr) function.
REQ-033 One sub-module, fft_out_fifo: 4-entry synchronous FIFO of {data, index, last}, with push/pop/full/empty.

Verification
REQ-034 Banks preloaded with data = p, iREADY=1, iFFT_RDY edge -> indices 0..2047 in order; index 1 returns data 512, index 4 returns data 128; oLAST and oDONE occur exactly once.
REQ-035 Random iREADY (50%) -> same 2048-sample sequence; held-data check on every stall; FIFO occupancy never exceeds 4.
REQ-036 iREADY=0 for 100 cycles after start -> exactly 4 reads issued, then oRD_EN=0 until iREADY rises.
REQ-037 iFFT_RDY toggled 0->1 again mid-frame -> ignored; exactly 2048 samples are delivered.
REQ-038 iRESET pulse at sample 700 -> all outputs take reset values next cycle; a new edge restarts at index 0.
REQ-039 iFFT_RDY already high when reset releases -> no frame until it drops and rises again.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, types and the frequency-index to (bank, address) mapping
// for the 2048-point FFT result reader.
package fft_pkg;
   localparam int N_FFT       = 2048;
   localparam int BANK_ADDR_W = 9;
   localparam int INDEX_W     = 11;
   localparam int BANK_W      = 2;
   localparam int FIFO_DEPTH  = 4;
   localparam int FIFO_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(N_FFT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   typedef struct packed {
      logic [BANK_W-1:0]      bank;
      logic [BANK_ADDR_W-1:0] addr;
   } rd_loc_t;

   // One issued read travelling through the RAM latency pipeline.
   typedef struct packed {
      logic                   vld;
      logic [BANK_W-1:0]      bank;
      logic [INDEX_W-1:0]     idx;
   } rd_tag_t;

   // Radix-4 digits reverse order; the single radix-2 digit d5 lands in the LSB.
   function automatic rd_loc_t digit_rev(input logic [INDEX_W-1:0] n);
      return rd_loc_t'({n[1:0], n[3:2], n[5:4], n[7:6], n[9:8], n[10]});
   endfunction
endpackage

// File: rtl/fft_out_fifo.sv
// Small synchronous FIFO holding {data, index, last} between the bank reads
// and the output handshake; a push and pop in the same cycle both take effect.
module fft_out_fifo
   import fft_pkg::*;
#(
   parameter int W = 44
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_push,
   input  logic [W-1:0]          i_data,
   input  logic                  i_pop,
   output logic [W-1:0]          o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [FIFO_CNT_W-1:0] o_count
);

   logic [W-1:0]          r_mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] r_wr_ptr;
   logic [FIFO_PTR_W-1:0] r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // NOTE: storage is deliberately not reset; only pointers/count are, and the
   // parent gates everything read from here with "not empty".
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
         r_count <= r_count + FIFO_CNT_W'(w_do_push) - FIFO_CNT_W'(w_do_pop);
      end
   end

   assign o_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/fft_output_reader.sv
// Streams a finished 2048-point FFT out of four digit-reversed RAM banks in
// natural frequency order over a valid/ready interface.
module fft_output_reader
   import fft_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic                   iCLK,
   input  logic                   iRESET,
   input  logic                   iFFT_RDY,
   output logic                   oRD_EN,
   output logic [BANK_W-1:0]      oRD_BANK,
   output logic [BANK_ADDR_W-1:0] oRD_ADDR,
   input  logic [2*DATA_W-1:0]    iRD_DATA_0,
   input  logic [2*DATA_W-1:0]    iRD_DATA_1,
   input  logic [2*DATA_W-1:0]    iRD_DATA_2,
   input  logic [2*DATA_W-1:0]    iRD_DATA_3,
   output logic                   oVALID,
   input  logic                   iREADY,
   output logic [2*DATA_W-1:0]    oDATA,
   output logic [INDEX_W-1:0]     oINDEX,
   output logic                   oLAST,
   output logic                   oBUSY,
   output logic                   oDONE
);

   localparam int SMP_W = 2 * DATA_W;
   localparam int ENT_W = SMP_W + INDEX_W + 1;
   localparam int CRD_W = $clog2(RD_LAT + FIFO_DEPTH + 1) + 1;

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_rdy_d;
   logic [INDEX_W-1:0]    r_rd_idx;
   rd_tag_t               r_pipe [RD_LAT];
   logic                  r_done;

   rd_loc_t               w_loc;
   rd_tag_t               w_tail;
   logic                  w_start;
   logic                  w_last_rd;
   logic                  w_rd_en;
   logic                  w_credit_ok;
   logic [CRD_W-1:0]      w_in_flight;
   logic [SMP_W-1:0]      w_rd_data;
   logic [ENT_W-1:0]      w_push_ent;
   logic [ENT_W-1:0]      w_head_ent;
   logic                  w_valid;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_head_last;
   logic [FIFO_CNT_W-1:0] w_fifo_count;

   assign w_loc       = digit_rev(r_rd_idx);
   assign w_tail      = r_pipe[RD_LAT-1];
   assign w_start     = iFFT_RDY && !r_rdy_d;
   assign w_last_rd   = (r_rd_idx == LAST_IDX);
   assign w_valid     = !w_empty;
   assign w_pop       = w_valid && iREADY;
   assign w_head_last = w_head_ent[0];

   always_ff @(posedge iCLK) begin
      if (iRESET) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_start)               w_next_state = S_RUN;
         S_RUN:   if (w_rd_en && w_last_rd)  w_next_state = S_DRAIN;
         S_DRAIN: if (w_pop && w_head_last)  w_next_state = S_IDLE;
         default:                            w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_en  = 1'b0;
      oRD_BANK = '0;
      oRD_ADDR = '0;
      oBUSY    = 1'b0;
      case (r_state)
         S_RUN: begin
            w_rd_en  = w_credit_ok;
            oRD_BANK = w_loc.bank;
            oRD_ADDR = w_loc.addr;
            oBUSY    = 1'b1;
         end
         S_DRAIN: oBUSY = 1'b1;
         default: ;
      endcase
   end

   assign oRD_EN = w_rd_en;

   // Reset leaves the edge register high so an already-high level cannot start a frame.
   always_ff @(posedge iCLK) begin
      if (iRESET) r_rdy_d <= 1'b1;
      else        r_rdy_d <= iFFT_RDY;
   end

   always_ff @(posedge iCLK) begin
      if (iRESET || r_state == S_IDLE) r_rd_idx <= '0;
      else if (w_rd_en && !w_last_rd)  r_rd_idx <= r_rd_idx + INDEX_W'(1);
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= '{vld: w_rd_en, bank: w_loc.bank, idx: r_rd_idx};
         for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   // Reads still in the RAM pipeline each already own a FIFO slot.
   always_comb begin
      w_in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) w_in_flight = w_in_flight + CRD_W'(r_pipe[i].vld);
   end

   assign w_credit_ok = !w_full &&
                        ((w_in_flight + CRD_W'(w_fifo_count)) < CRD_W'(FIFO_DEPTH));

   always_comb begin
      case (w_tail.bank)
         2'd0:    w_rd_data = iRD_DATA_0;
         2'd1:    w_rd_data = iRD_DATA_1;
         2'd2:    w_rd_data = iRD_DATA_2;
         default: w_rd_data = iRD_DATA_3;
      endcase
   end

   assign w_push_ent = {w_rd_data, w_tail.idx, (w_tail.idx == LAST_IDX)};

   fft_out_fifo #(
      .W (ENT_W)
   ) u_fifo (
      .i_clk   (iCLK),
      .i_reset (iRESET),
      .i_push  (w_tail.vld),
      .i_data  (w_push_ent),
      .i_pop   (w_pop),
      .o_data  (w_head_ent),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fifo_count)
   );

   assign oVALID = w_valid;
   assign oDATA  = w_valid ? w_head_ent[ENT_W-1 -: SMP_W] : '0;
   assign oINDEX = w_valid ? w_head_ent[INDEX_W:1]        : '0;
   assign oLAST  = w_valid && w_head_last;

   always_ff @(posedge iCLK) begin
      if (iRESET) r_done <= 1'b0;
      else        r_done <= w_pop && w_head_last;
   end

   assign oDONE = r_done;

endmodule

// File: tb/tb_fft_output_reader.sv
// Scoreboard bench for fft_output_reader: a behavioural bank RAM, a natural-order
// expected stream built from base-4 digit reversal, and a decoupled output monitor.
module tb_fft_output_reader;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;
   localparam int N      = 2048;
   localparam int SW     = 2 * DATA_W;

   logic          iCLK = 1'b0;
   logic          iRESET;
   logic          iFFT_RDY;
   logic          iREADY;
   logic          oRD_EN;
   logic [1:0]    oRD_BANK;
   logic [8:0]    oRD_ADDR;
   logic [SW-1:0] iRD_DATA_0, iRD_DATA_1, iRD_DATA_2, iRD_DATA_3;
   logic          oVALID;
   logic [SW-1:0] oDATA;
   logic [10:0]   oINDEX;
   logic          oLAST;
   logic          oBUSY;
   logic          oDONE;

   always #5 iCLK = ~iCLK;

   fft_output_reader #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iFFT_RDY   (iFFT_RDY),
      .oRD_EN     (oRD_EN),
      .oRD_BANK   (oRD_BANK),
      .oRD_ADDR   (oRD_ADDR),
      .iRD_DATA_0 (iRD_DATA_0),
      .iRD_DATA_1 (iRD_DATA_1),
      .iRD_DATA_2 (iRD_DATA_2),
      .iRD_DATA_3 (iRD_DATA_3),
      .oVALID     (oVALID),
      .iREADY     (iREADY),
      .oDATA      (oDATA),
      .oINDEX     (oINDEX),
      .oLAST      (oLAST),
      .oBUSY      (oBUSY),
      .oDONE      (oDONE)
   );

   typedef struct packed {
      logic [SW-1:0] data;
      logic [10:0]   idx;
      logic          last;
   } exp_t;

   exp_t          sb[$];
   logic [SW-1:0] mem [N];
   logic [SW-1:0] bank_q [4][RD_LAT];

   int n_vec       = 0;
   int n_err       = 0;
   int rd_count    = 0;
   int hs_count    = 0;
   int frame_hs    = 0;
   int last_count  = 0;
   int done_count  = 0;
   int ready_mode  = 1;

   bit            prev_stall   = 1'b0;
   bit            last_hs_prev = 1'b0;
   logic [SW-1:0] held_data;
   logic [10:0]   held_idx;
   logic          held_last;
   logic [SW-1:0] data_at1 = '0;
   logic [SW-1:0] data_at4 = '0;

   task automatic check(input string name, input bit ok, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Storage position: base-4 digits of the low 10 bits reversed, top bit appended last.
   function automatic int ref_pos(input int n);
      int rest, p;
      p    = n / 1024;
      rest = n % 1024;
      for (int k = 0; k < 5; k++)
         p += ((rest / (1 << (2 * k))) % 4) * (2 * (1 << (2 * (4 - k))));
      return p;
   endfunction

   // Bank RAMs: only the addressed bank returns stored data, the others return noise.
   always @(posedge iCLK) begin
      for (int b = 0; b < 4; b++) begin
         for (int s = RD_LAT - 1; s > 0; s--) bank_q[b][s] <= bank_q[b][s-1];
         if (oRD_EN && oRD_BANK == 2'(b)) bank_q[b][0] <= mem[b * 512 + int'(oRD_ADDR)];
         else                             bank_q[b][0] <= $urandom;
      end
   end

   assign iRD_DATA_0 = bank_q[0][RD_LAT-1];
   assign iRD_DATA_1 = bank_q[1][RD_LAT-1];
   assign iRD_DATA_2 = bank_q[2][RD_LAT-1];
   assign iRD_DATA_3 = bank_q[3][RD_LAT-1];

   always @(posedge iCLK) begin
      if (iRESET)      rd_count <= 0;
      else if (oRD_EN) rd_count <= rd_count + 1;
   end

   initial begin
      iREADY = 1'b1;
      forever begin
         @(posedge iCLK);
         #1;
         case (ready_mode)
            0:       iREADY = 1'b0;
            1:       iREADY = 1'b1;
            default: iREADY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: samples on the falling edge, between the active edges.
   always @(negedge iCLK) begin
      if (iRESET) begin
         prev_stall   = 1'b0;
         last_hs_prev = 1'b0;
         hs_count     = 0;
      end else begin
         check("done_pulse", oDONE == last_hs_prev, 64'(oDONE), 64'(last_hs_prev));
         if (oDONE) done_count++;
         check("outstanding_le_4", (rd_count - hs_count) <= 4, 64'(rd_count - hs_count), 64'd4);
         if (prev_stall) begin
            check("stall_hold_valid", oVALID == 1'b1, 64'(oVALID), 64'd1);
            check("stall_hold_data", oDATA == held_data, 64'(oDATA), 64'(held_data));
            check("stall_hold_index", oINDEX == held_idx, 64'(oINDEX), 64'(held_idx));
            check("stall_hold_last", oLAST == held_last, 64'(oLAST), 64'(held_last));
         end
         last_hs_prev = 1'b0;
         if (oVALID && iREADY) begin
            if (sb.size() == 0) begin
               check("unexpected_sample", 1'b0, 64'(oINDEX), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sample_data", oDATA == e.data, 64'(oDATA), 64'(e.data));
               check("sample_index", oINDEX == e.idx, 64'(oINDEX), 64'(e.idx));
               check("sample_last", oLAST == e.last, 64'(oLAST), 64'(e.last));
            end
            if (oINDEX == 11'd1) data_at1 = oDATA;
            if (oINDEX == 11'd4) data_at4 = oDATA;
            if (oLAST) begin
               last_count++;
               last_hs_prev = 1'b1;
            end
            hs_count++;
            frame_hs++;
         end
         prev_stall = oVALID && !iREADY;
         held_data  = oDATA;
         held_idx   = oINDEX;
         held_last  = oLAST;
      end
   end

   task automatic check_reset_outputs();
      check("rst_rd_en", oRD_EN == 1'b0, 64'(oRD_EN), 64'd0);
      check("rst_rd_bank", oRD_BANK == 2'd0, 64'(oRD_BANK), 64'd0);
      check("rst_rd_addr", oRD_ADDR == 9'd0, 64'(oRD_ADDR), 64'd0);
      check("rst_valid", oVALID == 1'b0, 64'(oVALID), 64'd0);
      check("rst_data", oDATA == '0, 64'(oDATA), 64'd0);
      check("rst_index", oINDEX == 11'd0, 64'(oINDEX), 64'd0);
      check("rst_last", oLAST == 1'b0, 64'(oLAST), 64'd0);
      check("rst_busy", oBUSY == 1'b0, 64'(oBUSY), 64'd0);
      check("rst_done", oDONE == 1'b0, 64'(oDONE), 64'd0);
   endtask

   // Queue the whole expected frame, then present a fresh 0->1 edge on iFFT_RDY.
   task automatic start_frame();
      @(posedge iCLK);
      #1 iFFT_RDY = 1'b0;
      @(posedge iCLK);
      #1;
      frame_hs   = 0;
      last_count = 0;
      done_count = 0;
      for (int n = 0; n < N; n++)
         sb.push_back('{data: mem[ref_pos(n)], idx: 11'(n), last: (n == N - 1)});
      iFFT_RDY = 1'b1;
   endtask

   task automatic wait_done();
      int cyc;
      cyc = 0;
      while (!oDONE && cyc < 20000) begin
         @(posedge iCLK);
         #1 cyc++;
      end
      check("frame_done_seen", oDONE == 1'b1, 64'(oDONE), 64'd1);
   endtask

   task automatic end_checks();
      repeat (3) @(posedge iCLK);
      #1;
      check("frame_sb_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
      check("frame_sample_count", frame_hs == N, 64'(frame_hs), 64'(N));
      check("frame_last_count", last_count == 1, 64'(last_count), 64'd1);
      check("frame_done_count", done_count == 1, 64'(done_count), 64'd1);
      check("frame_busy_clear", oBUSY == 1'b0, 64'(oBUSY), 64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, cyc, rd0, wait_cyc;
      iRESET   = 1'b1;
      iFFT_RDY = 1'b1;
      ready_mode = 1;
      for (int i = 0; i < N; i++) mem[i] = SW'(i);

      // Reset values, and an iFFT_RDY level that was already high must not start a frame.
      repeat (3) @(posedge iCLK);
      #1 check_reset_outputs();
      iRESET = 1'b0;
      repeat (20) @(posedge iCLK);
      #1;
      check("hi_level_no_busy", oBUSY == 1'b0, 64'(oBUSY), 64'd0);
      check("hi_level_no_reads", rd_count == 0, 64'(rd_count), 64'd0);
      check("hi_level_no_valid", oVALID == 1'b0, 64'(oVALID), 64'd0);

      // Frame 1: data = storage position, ready always high; latency and no-bubble timing.
      start_frame();
      cnt = 0;
      while (cnt < 20) begin
         @(posedge iCLK);
         #1 cnt++;
         if (cnt == 1) check("busy_after_start", oBUSY == 1'b1, 64'(oBUSY), 64'd1);
         if (oVALID) break;
      end
      check("first_valid_latency", cnt == RD_LAT + 2, 64'(cnt), 64'(RD_LAT + 2));
      cyc = 0;
      while (!oDONE && cyc < 5000) begin
         @(posedge iCLK);
         #1 cyc++;
      end
      check("stream_cycles_no_bubble", cyc == N, 64'(cyc), 64'(N));
      end_checks();
      check("index1_data", data_at1 == SW'(512), 64'(data_at1), 64'd512);
      check("index4_data", data_at4 == SW'(128), 64'(data_at4), 64'd128);

      // Frame 2: random data, random ready.
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      ready_mode = 2;
      start_frame();
      wait_done();
      end_checks();

      // Frame 3: downstream blocked for 100 cycles; only the FIFO depth may be read ahead.
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      ready_mode = 0;
      rd0 = rd_count;
      start_frame();
      repeat (100) @(posedge iCLK);
      #1;
      check("blocked_reads", (rd_count - rd0) == 4, 64'(rd_count - rd0), 64'd4);
      check("blocked_rd_en_low", oRD_EN == 1'b0, 64'(oRD_EN), 64'd0);
      check("blocked_valid", oVALID == 1'b1, 64'(oVALID), 64'd1);
      ready_mode = 2;
      wait_done();
      end_checks();

      // Frame 4: a second iFFT_RDY edge mid-frame is ignored.
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      start_frame();
      repeat (300) @(posedge iCLK);
      #1 iFFT_RDY = 1'b0;
      repeat (5) @(posedge iCLK);
      #1 iFFT_RDY = 1'b1;
      wait_done();
      end_checks();
      rd0 = rd_count;
      repeat (20) @(posedge iCLK);
      #1;
      check("no_restart_busy", oBUSY == 1'b0, 64'(oBUSY), 64'd0);
      check("no_restart_valid", oVALID == 1'b0, 64'(oVALID), 64'd0);
      check("no_restart_reads", rd_count == rd0, 64'(rd_count), 64'(rd0));

      // Frame 5: reset at sample 700 aborts; a new edge restarts from index 0.
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      start_frame();
      wait_cyc = 0;
      while (frame_hs < 700 && wait_cyc < 10000) begin
         @(posedge iCLK);
         #1 wait_cyc++;
      end
      check("reached_sample_700", frame_hs >= 700, 64'(frame_hs), 64'd700);
      iRESET = 1'b1;
      @(posedge iCLK);
      #1 check_reset_outputs();
      iRESET = 1'b0;
      sb.delete();
      repeat (20) @(posedge iCLK);
      #1;
      check("abort_no_reads", rd_count == 0, 64'(rd_count), 64'd0);
      check("abort_no_valid", oVALID == 1'b0, 64'(oVALID), 64'd0);
      check("abort_no_busy", oBUSY == 1'b0, 64'(oBUSY), 64'd0);
      ready_mode = 1;
      start_frame();
      wait_done();
      end_checks();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
